// File: rtl/collision_detector_pkg.sv
// collision_detector_pkg: grid geometry, coordinate widths, snapshot layout and FSM states
package collision_detector_pkg;
    localparam int ROWS      = 5;
    localparam int COLS      = 11;
    localparam int COL_PITCH = 24;
    localparam int ROW_PITCH = 16;
    localparam int INV_W     = 16;
    localparam int INV_H     = 8;
    localparam int PLAYER_W  = 26;
    localparam int PLAYER_H  = 16;
    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int CW        = 10;
    localparam int XW        = CW + 1;
    localparam int N         = ROWS * COLS;
    localparam int IDXW      = $clog2(N);
    localparam int ROWW      = $clog2(ROWS);
    localparam int COLW      = $clog2(COLS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        PLAYER = 2'd2
    } state_t;

    // form_y is not held: the running row origin iy carries it through the scan
    typedef struct packed {
        logic [CW-1:0] form_x;
        logic [CW-1:0] player_x;
        logic [CW-1:0] player_y;
        logic          pb_active;
        logic [CW-1:0] pb_x;
        logic [CW-1:0] pb_y;
        logic          ib_active;
        logic [CW-1:0] ib_x;
        logic [CW-1:0] ib_y;
    } snap_t;
endpackage

// File: rtl/collision_detector_if.sv
// collision_detector_if: game-state inputs and collision outputs; wave_cleared exists only with COLLISION_WAVE_RESET_EN
interface collision_detector_if;
    import collision_detector_pkg::*;
    logic            frame_tick;
    logic [CW-1:0]   form_x;
    logic [CW-1:0]   form_y;
    logic [CW-1:0]   player_x;
    logic [CW-1:0]   player_y;
    logic            pb_active;
    logic [CW-1:0]   pb_x;
    logic [CW-1:0]   pb_y;
    logic            ib_active;
    logic [CW-1:0]   ib_x;
    logic [CW-1:0]   ib_y;
    logic            busy;
    logic            invader_collision;
    logic [IDXW-1:0] hit_index;
    logic            player_collision;
    logic            pb_clear;
    logic            ib_clear;
    logic [N-1:0]    alive;
`ifdef COLLISION_WAVE_RESET_EN
    logic            wave_cleared;
`endif

    modport master (
`ifdef COLLISION_WAVE_RESET_EN
        input  wave_cleared,
`endif
        output frame_tick, form_x, form_y, player_x, player_y,
        output pb_active, pb_x, pb_y, ib_active, ib_x, ib_y,
        input  busy, invader_collision, hit_index, player_collision,
        input  pb_clear, ib_clear, alive
    );

    modport slave (
`ifdef COLLISION_WAVE_RESET_EN
        output wave_cleared,
`endif
        input  frame_tick, form_x, form_y, player_x, player_y,
        input  pb_active, pb_x, pb_y, ib_active, ib_x, ib_y,
        output busy, invader_collision, hit_index, player_collision,
        output pb_clear, ib_clear, alive
    );
endinterface

// File: rtl/collision_detector_aabb_point_hit.sv
// aabb_point_hit: combinational test of a point against an inclusive axis-aligned box
module aabb_point_hit
    import collision_detector_pkg::*;
(
    input  logic          en,
    input  logic [XW-1:0] box_x,
    input  logic [XW-1:0] box_y,
    input  logic [XW-1:0] box_w,
    input  logic [XW-1:0] box_h,
    input  logic [CW-1:0] pt_x,
    input  logic [CW-1:0] pt_y,
    output logic          hit
);
    logic [XW-1:0] px, py;

    assign px  = {1'b0, pt_x};
    assign py  = {1'b0, pt_y};
    assign hit = en && px >= box_x && px <= box_x + box_w - XW'(1)
                    && py >= box_y && py <= box_y + box_h - XW'(1);
endmodule

// File: rtl/collision_detector.sv
// collision_detector: per-frame invader-grid and player collision scan; COLLISION_WAVE_RESET_EN adds wave_cleared and mask reload
module collision_detector
    import collision_detector_pkg::*;
(
    input  logic                 clk,
    input  logic                 arst,
    collision_detector_if.slave  bus
);
    state_t          state_q, state_d;
    snap_t           snap_q, snap_d;
    logic [IDXW-1:0] idx_q, idx_d, hit_index_q, hit_index_d;
    logic [ROWW-1:0] row_q, row_d;
    logic [COLW-1:0] col_q, col_d;
    logic [XW-1:0]   ix_q, ix_d, iy_q, iy_d;
    logic [N-1:0]    alive_q, alive_d;
    logic            inv_hit_q, inv_hit_d, ply_hit_q, ply_hit_d;
    logic            inv_hit, ply_hit;
`ifdef COLLISION_WAVE_RESET_EN
    logic            wave_q, wave_d;
`endif

    aabb_point_hit u_inv_hit (
        .en    (state_q == SCAN && snap_q.pb_active && alive_q[idx_q]),
        .box_x (ix_q),
        .box_y (iy_q),
        .box_w (XW'(INV_W)),
        .box_h (XW'(INV_H)),
        .pt_x  (snap_q.pb_x),
        .pt_y  (snap_q.pb_y),
        .hit   (inv_hit)
    );

    aabb_point_hit u_ply_hit (
        .en    (state_q == PLAYER && snap_q.ib_active),
        .box_x ({1'b0, snap_q.player_x}),
        .box_y ({1'b0, snap_q.player_y}),
        .box_w (XW'(PLAYER_W)),
        .box_h (XW'(PLAYER_H)),
        .pt_x  (snap_q.ib_x),
        .pt_y  (snap_q.ib_y),
        .hit   (ply_hit)
    );

    // next state: snapshot on tick, walk the grid with running origins, then test the player
    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        idx_d       = idx_q;
        row_d       = row_q;
        col_d       = col_q;
        ix_d        = ix_q;
        iy_d        = iy_q;
        hit_index_d = hit_index_q;
        alive_d     = alive_q;
        inv_hit_d   = 1'b0;
        ply_hit_d   = 1'b0;
`ifdef COLLISION_WAVE_RESET_EN
        wave_d      = 1'b0;
`endif
        case (state_q)
            IDLE: if (bus.frame_tick) begin
                snap_d.form_x    = bus.form_x;
                snap_d.player_x  = bus.player_x;
                snap_d.player_y  = bus.player_y;
                snap_d.pb_active = bus.pb_active;
                snap_d.pb_x      = bus.pb_x;
                snap_d.pb_y      = bus.pb_y;
                snap_d.ib_active = bus.ib_active;
                snap_d.ib_x      = bus.ib_x;
                snap_d.ib_y      = bus.ib_y;
                idx_d            = '0;
                row_d            = '0;
                col_d            = '0;
                ix_d             = {1'b0, bus.form_x};
                iy_d             = {1'b0, bus.form_y};
                state_d          = SCAN;
            end
            SCAN: if (inv_hit) begin
                hit_index_d    = idx_q;
                alive_d[idx_q] = 1'b0;
                inv_hit_d      = 1'b1;
                state_d        = PLAYER;
            end else if (idx_q == IDXW'(N - 1)) begin
                state_d = PLAYER;
            end else begin
                idx_d = idx_q + 1'b1;
                if (col_q == COLW'(COLS - 1)) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                    ix_d  = {1'b0, snap_q.form_x};
                    iy_d  = iy_q + XW'(ROW_PITCH);
                end else begin
                    col_d = col_q + 1'b1;
                    ix_d  = ix_q + XW'(COL_PITCH);
                end
            end
            PLAYER: begin
                ply_hit_d = ply_hit;
                state_d   = IDLE;
`ifdef COLLISION_WAVE_RESET_EN
                if (inv_hit_q && alive_q == '0) begin
                    wave_d  = 1'b1;
                    alive_d = '1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers; reset aborts any scan and revives the whole grid
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= IDLE;
            snap_q      <= '0;
            idx_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            ix_q        <= '0;
            iy_q        <= '0;
            hit_index_q <= '0;
            alive_q     <= '1;
            inv_hit_q   <= 1'b0;
            ply_hit_q   <= 1'b0;
`ifdef COLLISION_WAVE_RESET_EN
            wave_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            idx_q       <= idx_d;
            row_q       <= row_d;
            col_q       <= col_d;
            ix_q        <= ix_d;
            iy_q        <= iy_d;
            hit_index_q <= hit_index_d;
            alive_q     <= alive_d;
            inv_hit_q   <= inv_hit_d;
            ply_hit_q   <= ply_hit_d;
`ifdef COLLISION_WAVE_RESET_EN
            wave_q      <= wave_d;
`endif
        end
    end

    assign bus.busy              = state_q != IDLE;
    assign bus.invader_collision = inv_hit_q;
    assign bus.pb_clear          = inv_hit_q;
    assign bus.player_collision  = ply_hit_q;
    assign bus.ib_clear          = ply_hit_q;
    assign bus.hit_index         = hit_index_q;
    assign bus.alive             = alive_q;
`ifdef COLLISION_WAVE_RESET_EN
    assign bus.wave_cleared      = wave_q;
`endif
endmodule

// File: tb/tb_collision_detector.sv
// tb_collision_detector: directed and randomized frames checked against a grid-geometry reference model
module tb_collision_detector;
    import collision_detector_pkg::*;

    logic clk = 1'b0;
    logic arst;
    int   checks = 0;
    int   failures = 0;

    collision_detector_if bus();
    collision_detector dut (.clk(clk), .arst(arst), .bus(bus.slave));

    always #5 clk = ~clk;

    logic [N-1:0] m_alive;
    int o_inv_cyc, o_inv_n, o_hit, o_pbc, o_ply_cyc, o_ply_n, o_ibc, o_busy1, o_low, o_wave_n, o_wave_cyc;
    logic [N-1:0] o_alive_inv, o_alive_end;
    int e_inv, e_hit, e_low, e_ply, e_wave;

    // reference: first live invader whose box holds the bullet, by plain grid arithmetic
    task automatic model_frame(input int fx, fy, plx, ply, pba, pbx, pby, iba, ibx, iby);
        int k, ix, iy;
        bit p;
        k = -1;
        for (int i = 0; i < N; i++) begin
            ix = fx + (i % COLS) * COL_PITCH;
            iy = fy + (i / COLS) * ROW_PITCH;
            if (k < 0 && pba != 0 && m_alive[i] && pbx >= ix && pbx < ix + INV_W && pby >= iy && pby < iy + INV_H) k = i;
        end
        p = iba != 0 && ibx >= plx && ibx < plx + PLAYER_W && iby >= ply && iby < ply + PLAYER_H;
        e_inv  = k < 0 ? -1 : 2 + k;
        e_hit  = k < 0 ? 0 : k;
        e_low  = k < 0 ? 2 + N : 3 + k;
        e_ply  = p ? e_low : -1;
        e_wave = -1;
        if (k >= 0) m_alive[k] = 1'b0;
`ifdef COLLISION_WAVE_RESET_EN
        if (k >= 0 && m_alive == '0) begin
            e_wave  = e_low;
            m_alive = '1;
        end
`endif
    endtask

    // drive one frame, scramble inputs after the tick, and record what the DUT reports
    task automatic do_frame(input int fx, fy, plx, ply, pba, pbx, pby, iba, ibx, iby, xtick, rst_at);
        @(posedge clk); #1;
        bus.form_x = 10'(fx); bus.form_y = 10'(fy); bus.player_x = 10'(plx); bus.player_y = 10'(ply);
        bus.pb_active = pba[0]; bus.pb_x = 10'(pbx); bus.pb_y = 10'(pby);
        bus.ib_active = iba[0]; bus.ib_x = 10'(ibx); bus.ib_y = 10'(iby);
        bus.frame_tick = 1'b1;
        o_inv_cyc = -1; o_inv_n = 0; o_hit = -1; o_pbc = 0; o_ply_cyc = -1; o_ply_n = 0; o_ibc = 0;
        o_busy1 = 0; o_low = -1; o_wave_n = 0; o_wave_cyc = -1; o_alive_inv = '0; o_alive_end = '0;
        for (int c = 1; c <= 70; c++) begin
            @(posedge clk); #1;
            if (c == rst_at) begin
                arst = 1'b1; #1; arst = 1'b0;
            end
            if (c == 1) o_busy1 = int'(bus.busy);
            if (bus.invader_collision) begin
                o_inv_n++;
                if (o_inv_cyc < 0) begin
                    o_inv_cyc = c; o_hit = int'(bus.hit_index); o_pbc = int'(bus.pb_clear); o_alive_inv = bus.alive;
                end
            end
            if (bus.player_collision) begin
                o_ply_n++;
                if (o_ply_cyc < 0) begin
                    o_ply_cyc = c; o_ibc = int'(bus.ib_clear);
                end
            end
`ifdef COLLISION_WAVE_RESET_EN
            if (bus.wave_cleared) begin
                o_wave_n++; o_wave_cyc = c;
            end
`endif
            if (!bus.busy) begin
                o_low = c; o_alive_end = bus.alive;
                break;
            end
            bus.frame_tick = (c == xtick);
            bus.form_x = 10'($urandom); bus.form_y = 10'($urandom); bus.pb_active = 1'($urandom);
            bus.pb_x = 10'($urandom); bus.pb_y = 10'($urandom); bus.ib_active = 1'($urandom);
            bus.ib_x = 10'($urandom); bus.ib_y = 10'($urandom);
            bus.player_x = 10'($urandom); bus.player_y = 10'($urandom);
        end
        bus.frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        arst = 1'b1;
        bus.frame_tick = 0; bus.form_x = 0; bus.form_y = 0; bus.player_x = 0; bus.player_y = 0;
        bus.pb_active = 0; bus.pb_x = 0; bus.pb_y = 0; bus.ib_active = 0; bus.ib_x = 0; bus.ib_y = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if ({bus.invader_collision, bus.player_collision, bus.pb_clear, bus.ib_clear} !== 4'b0) begin
            failures++; $display("FAIL reset_pulses got %b want 0000", {bus.invader_collision, bus.player_collision, bus.pb_clear, bus.ib_clear});
        end
        checks++; if (bus.hit_index !== '0) begin failures++; $display("FAIL reset_hit_index got %0d want 0", bus.hit_index); end
        checks++; if (bus.alive !== {N{1'b1}}) begin failures++; $display("FAIL reset_alive got %h want all ones", bus.alive); end
        arst = 1'b0;
        m_alive = '1;
    endtask

    task automatic test_hit_first();
        do_frame(100, 50, 0, 0, 1, 105, 52, 0, 0, 0, -1, -1);
        model_frame(100, 50, 0, 0, 1, 105, 52, 0, 0, 0);
        checks++; if (o_busy1 !== 1) begin failures++; $display("FAIL hit0_busy1 got %0d want 1", o_busy1); end
        checks++; if (o_inv_cyc !== 2) begin failures++; $display("FAIL hit0_cycle got %0d want 2", o_inv_cyc); end
        checks++; if (o_hit !== 0) begin failures++; $display("FAIL hit0_index got %0d want 0", o_hit); end
        checks++; if (o_pbc !== 1) begin failures++; $display("FAIL hit0_pb_clear got %0d want 1", o_pbc); end
        checks++; if (o_alive_inv[0] !== 1'b0) begin failures++; $display("FAIL hit0_alive0 got %b want 0", o_alive_inv[0]); end
        checks++; if (o_low !== 3) begin failures++; $display("FAIL hit0_busy_low got %0d want 3", o_low); end
        checks++; if (o_ply_n !== 0) begin failures++; $display("FAIL hit0_player_pulses got %0d want 0", o_ply_n); end
    endtask

    task automatic test_hit_mid();
        do_frame(100, 50, 0, 0, 1, 187, 89, 0, 0, 0, -1, -1);
        model_frame(100, 50, 0, 0, 1, 187, 89, 0, 0, 0);
        checks++; if (o_inv_cyc !== 27) begin failures++; $display("FAIL hit25_cycle got %0d want 27", o_inv_cyc); end
        checks++; if (o_hit !== 25) begin failures++; $display("FAIL hit25_index got %0d want 25", o_hit); end
        checks++; if (o_alive_end !== m_alive) begin failures++; $display("FAIL hit25_alive got %h want %h", o_alive_end, m_alive); end
        do_frame(100, 50, 0, 0, 1, 187, 89, 0, 0, 0, -1, -1);
        model_frame(100, 50, 0, 0, 1, 187, 89, 0, 0, 0);
        checks++; if (o_inv_n !== 0) begin failures++; $display("FAIL hit25_repeat_pulses got %0d want 0", o_inv_n); end
        checks++; if (o_low !== 57) begin failures++; $display("FAIL hit25_repeat_busy_low got %0d want 57", o_low); end
    endtask

    task automatic test_player();
        do_frame(100, 50, 300, 440, 0, 0, 0, 1, 310, 450, -1, -1);
        model_frame(100, 50, 300, 440, 0, 0, 0, 1, 310, 450);
        checks++; if (o_inv_n !== 0) begin failures++; $display("FAIL player_inv_pulses got %0d want 0", o_inv_n); end
        checks++; if (o_ply_cyc !== 57) begin failures++; $display("FAIL player_cycle got %0d want 57", o_ply_cyc); end
        checks++; if (o_ibc !== 1) begin failures++; $display("FAIL player_ib_clear got %0d want 1", o_ibc); end
        checks++; if (o_low !== 57) begin failures++; $display("FAIL player_busy_low got %0d want 57", o_low); end
        do_frame(100, 50, 300, 440, 0, 0, 0, 1, 326, 450, -1, -1);
        model_frame(100, 50, 300, 440, 0, 0, 0, 1, 326, 450);
        checks++; if (o_ply_n !== 0) begin failures++; $display("FAIL player_edge_pulses got %0d want 0", o_ply_n); end
    endtask

    task automatic test_ignored_tick();
        int extra;
        do_frame(100, 50, 0, 0, 0, 0, 0, 0, 0, 0, 10, -1);
        model_frame(100, 50, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (o_low !== 57) begin failures++; $display("FAIL retick_busy_low got %0d want 57", o_low); end
        extra = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.busy) extra++;
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL retick_second_scan got %0d busy cycles want 0", extra); end
    endtask

    task automatic test_abort();
        do_frame(100, 50, 300, 440, 1, 295, 85, 1, 310, 450, -1, 20);
        m_alive = '1;
        checks++; if (o_low !== 20) begin failures++; $display("FAIL abort_busy_low got %0d want 20", o_low); end
        checks++; if (o_inv_n + o_ply_n !== 0) begin failures++; $display("FAIL abort_pulses got %0d want 0", o_inv_n + o_ply_n); end
        checks++; if (o_alive_end !== {N{1'b1}}) begin failures++; $display("FAIL abort_alive got %h want all ones", o_alive_end); end
    endtask

    task automatic test_random();
        int fx, fy, t, ix, iy, pba, pbx, pby, plx, ply, iba, ibx, iby;
        for (int f = 0; f < 30; f++) begin
            fx = $urandom_range(1, 700); fy = $urandom_range(1, 400);
            t = $urandom_range(0, N - 1);
            ix = fx + (t % COLS) * COL_PITCH; iy = fy + (t / COLS) * ROW_PITCH;
            pba = ($urandom_range(0, 9) < 8) ? 1 : 0;
            if ($urandom_range(0, 4) == 0) begin
                pbx = $urandom_range(0, 1023); pby = $urandom_range(0, 1023);
            end else begin
                pbx = ix + $urandom_range(0, INV_W + 1) - 1; pby = iy + $urandom_range(0, INV_H + 1) - 1;
            end
            plx = $urandom_range(1, 900); ply = $urandom_range(1, 400);
            iba = $urandom_range(0, 1);
            ibx = plx + $urandom_range(0, PLAYER_W + 1) - 1; iby = ply + $urandom_range(0, PLAYER_H + 1) - 1;
            do_frame(fx, fy, plx, ply, pba, pbx, pby, iba, ibx, iby, -1, -1);
            model_frame(fx, fy, plx, ply, pba, pbx, pby, iba, ibx, iby);
            checks++; if (o_inv_cyc !== e_inv) begin failures++; $display("FAIL rand%0d_inv_cycle got %0d want %0d", f, o_inv_cyc, e_inv); end
            checks++; if (e_inv >= 0 && o_hit !== e_hit) begin failures++; $display("FAIL rand%0d_hit_index got %0d want %0d", f, o_hit, e_hit); end
            checks++; if (o_ply_cyc !== e_ply) begin failures++; $display("FAIL rand%0d_player_cycle got %0d want %0d", f, o_ply_cyc, e_ply); end
            checks++; if (o_low !== e_low) begin failures++; $display("FAIL rand%0d_busy_low got %0d want %0d", f, o_low, e_low); end
            checks++; if (o_alive_end !== m_alive) begin failures++; $display("FAIL rand%0d_alive got %h want %h", f, o_alive_end, m_alive); end
        end
    endtask

    task automatic test_wave();
        int waves, last_wave;
        @(posedge clk); #1;
        arst = 1'b1; #1; arst = 1'b0;
        m_alive = '1;
        waves = 0; last_wave = -1;
        for (int k = 0; k < N; k++) begin
            do_frame(100, 50, 0, 0, 1, 100 + (k % COLS) * COL_PITCH + 3, 50 + (k / COLS) * ROW_PITCH + 2, 0, 0, 0, -1, -1);
            model_frame(100, 50, 0, 0, 1, 100 + (k % COLS) * COL_PITCH + 3, 50 + (k / COLS) * ROW_PITCH + 2, 0, 0, 0);
            checks++; if (o_inv_cyc !== 2 + k || o_hit !== k) begin
                failures++; $display("FAIL wave_kill%0d got cycle %0d index %0d want cycle %0d index %0d", k, o_inv_cyc, o_hit, 2 + k, k);
            end
            waves += o_wave_n;
            if (o_wave_n != 0) last_wave = o_wave_cyc;
        end
        checks++; if (o_alive_end !== m_alive) begin failures++; $display("FAIL wave_alive got %h want %h", o_alive_end, m_alive); end
`ifdef COLLISION_WAVE_RESET_EN
        checks++; if (waves !== 1) begin failures++; $display("FAIL wave_pulses got %0d want 1", waves); end
        checks++; if (last_wave !== e_wave) begin failures++; $display("FAIL wave_cycle got %0d want %0d", last_wave, e_wave); end
        checks++; if (o_alive_end !== {N{1'b1}}) begin failures++; $display("FAIL wave_reload got %h want all ones", o_alive_end); end
`else
        checks++; if (o_alive_end !== {N{1'b0}}) begin failures++; $display("FAIL wave_stays_dead got %h want 0", o_alive_end); end
        do_frame(100, 50, 0, 0, 1, 103, 52, 0, 0, 0, -1, -1);
        checks++; if (o_inv_n !== 0) begin failures++; $display("FAIL wave_dead_grid_pulses got %0d want 0", o_inv_n); end
`endif
    endtask

    initial begin
        test_reset();
        test_hit_first();
        test_hit_mid();
        test_player();
        test_ignored_tick();
        test_abort();
        test_random();
        test_wave();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
